// File: rtl/pdm_mic_sampler_if.sv
// Write port from the PDM sampler into the downstream PCM sample FIFO.
// Handshake: wr is a one-cycle strobe. It is raised only when full was low in the
// cycle the sample completed. din is valid while wr is high and holds until the next update.
interface pdm_mic_sampler_if;
    logic [7:0] din;
    logic       wr;
    logic       full;

    modport master (output din, output wr, input full);
    modport slave  (input din, input wr, output full);
endinterface

// File: rtl/pdm_mic_sampler.sv
// PDM microphone front end: drives mic_clk, captures one bit per mic_clk period
// and box-filters DEC bits into an 8-bit ones-count PCM sample for the FIFO.
module pdm_mic_sampler #(
    parameter int CLK_DIV = 50,
    parameter int DEC     = 255,
    parameter int WARM    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rec,
    input  logic              mic_data,
    pdm_mic_sampler_if.master fifo,
    output logic              mic_clk,
    output logic              mic_lrsel,
    output logic              overflow,
    output logic              active,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [9:0] DIV_LAST  = 10'(CLK_DIV - 1);
    localparam logic [7:0] DEC_LAST  = 8'(DEC - 1);
    localparam logic [3:0] WARM_LAST = (WARM == 0) ? 4'd0 : 4'(WARM - 1);
    localparam bit         WARM_SKIP = (WARM == 0);

    state_t     state;
    logic [9:0] div_cnt;
    logic [7:0] ones;
    logic [7:0] bitcnt;
    logic [3:0] warm_cnt;

    logic       div_wrap;
    logic       capture;
    logic       last_bit;
    logic [7:0] ones_next;

    // A bit is taken on the last system clock of the mic_clk high phase.
    always_comb begin
        div_wrap  = (div_cnt == DIV_LAST);
        capture   = (state != S_IDLE) && mic_clk && div_wrap;
        last_bit  = capture && (bitcnt == DEC_LAST);
        ones_next = ones + {7'd0, mic_data};
    end

    assign mic_lrsel = 1'b0;
    assign dbg_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            mic_clk   <= 1'b0;
            ones      <= '0;
            bitcnt    <= '0;
            warm_cnt  <= '0;
            fifo.din  <= '0;
            fifo.wr   <= 1'b0;
            overflow  <= 1'b0;
            active    <= 1'b0;
        end else begin
            fifo.wr <= 1'b0;
            if (state == S_IDLE) begin
                div_cnt  <= '0;
                mic_clk  <= 1'b0;
                ones     <= '0;
                bitcnt   <= '0;
                warm_cnt <= '0;
                if (rec) begin
                    state  <= WARM_SKIP ? S_RUN : S_WARM;
                    active <= WARM_SKIP;
                end
            end else if (!rec) begin
                // Abort: the partial sample and warm-up progress are dropped silently.
                state    <= S_IDLE;
                div_cnt  <= '0;
                mic_clk  <= 1'b0;
                ones     <= '0;
                bitcnt   <= '0;
                warm_cnt <= '0;
                active   <= 1'b0;
            end else begin
                if (div_wrap) begin
                    div_cnt <= '0;
                    mic_clk <= ~mic_clk;
                end else begin
                    div_cnt <= div_cnt + 10'd1;
                end

                if (last_bit) begin
                    fifo.din <= ones_next;
                    ones     <= '0;
                    bitcnt   <= '0;
                    if (state == S_WARM) begin
                        if (warm_cnt == WARM_LAST) begin
                            state    <= S_RUN;
                            active   <= 1'b1;
                            warm_cnt <= '0;
                        end else begin
                            warm_cnt <= warm_cnt + 4'd1;
                        end
                    end else if (fifo.full) begin
                        overflow <= 1'b1;
                    end else begin
                        fifo.wr <= 1'b1;
                    end
                end else if (capture) begin
                    ones   <= ones_next;
                    bitcnt <= bitcnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pdm_mic_sampler.sv
// Bench for pdm_mic_sampler: four parameterisations share one stimulus stream and
// are checked every cycle against a timeline model, plus directed literal checks.
module tb_pdm_mic_sampler;
    localparam int NI = 4;

    // Instance 0: (2,8,2)  1: (2,255,0)  2: (2,8,0)  3: (3,5,1)
    int cd [NI] = '{2, 2, 2, 3};
    int dc [NI] = '{8, 255, 8, 5};
    int wm [NI] = '{2, 0, 0, 1};

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic rec      = 1'b0;
    logic mic_data = 1'b0;
    logic full     = 1'b0;

    logic [NI-1:0] mclk, lrsel, ovf, act;
    logic [1:0]    dbg0, dbg1, dbg2, dbg3;
    logic [7:0]    din_v [NI];
    logic [NI-1:0] wr_v;

    int  checks = 0;
    int  errors = 0;
    bit  cmp_en = 1'b0;

    pdm_mic_sampler_if if0 ();
    pdm_mic_sampler_if if1 ();
    pdm_mic_sampler_if if2 ();
    pdm_mic_sampler_if if3 ();

    assign if0.full = full;
    assign if1.full = full;
    assign if2.full = full;
    assign if3.full = full;

    always_comb begin
        din_v[0] = if0.din;  wr_v[0] = if0.wr;
        din_v[1] = if1.din;  wr_v[1] = if1.wr;
        din_v[2] = if2.din;  wr_v[2] = if2.wr;
        din_v[3] = if3.din;  wr_v[3] = if3.wr;
    end

    pdm_mic_sampler #(.CLK_DIV(2), .DEC(8), .WARM(2)) u0 (
        .clock(clock), .reset(reset), .rec(rec), .mic_data(mic_data), .fifo(if0),
        .mic_clk(mclk[0]), .mic_lrsel(lrsel[0]), .overflow(ovf[0]), .active(act[0]),
        .dbg_state(dbg0));
    pdm_mic_sampler #(.CLK_DIV(2), .DEC(255), .WARM(0)) u1 (
        .clock(clock), .reset(reset), .rec(rec), .mic_data(mic_data), .fifo(if1),
        .mic_clk(mclk[1]), .mic_lrsel(lrsel[1]), .overflow(ovf[1]), .active(act[1]),
        .dbg_state(dbg1));
    pdm_mic_sampler #(.CLK_DIV(2), .DEC(8), .WARM(0)) u2 (
        .clock(clock), .reset(reset), .rec(rec), .mic_data(mic_data), .fifo(if2),
        .mic_clk(mclk[2]), .mic_lrsel(lrsel[2]), .overflow(ovf[2]), .active(act[2]),
        .dbg_state(dbg2));
    pdm_mic_sampler #(.CLK_DIV(3), .DEC(5), .WARM(1)) u3 (
        .clock(clock), .reset(reset), .rec(rec), .mic_data(mic_data), .fifo(if3),
        .mic_clk(mclk[3]), .mic_lrsel(lrsel[3]), .overflow(ovf[3]), .active(act[3]),
        .dbg_state(dbg3));

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Time-line view: t counts cycles since leaving IDLE; mic_clk is high in the
    // second half of every 2*CLK_DIV window and a bit is taken at the window's end.
    bit            m_run [NI];
    int            m_t   [NI];
    int            m_nb  [NI];
    int            m_ns  [NI];
    logic [254:0]  m_buf [NI];
    logic [7:0]    exp_din [NI];
    logic [NI-1:0] exp_wr, exp_ovf, exp_act, exp_mclk;

    always @(posedge clock or posedge reset) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_run[i]    = 1'b0;
                m_t[i]      = 0;
                m_nb[i]     = 0;
                m_ns[i]     = 0;
                m_buf[i]    = '0;
                exp_din[i]  = 8'd0;
                exp_wr[i]   = 1'b0;
                exp_ovf[i]  = 1'b0;
                exp_act[i]  = 1'b0;
                exp_mclk[i] = 1'b0;
            end else begin
                exp_wr[i] = 1'b0;
                if (!m_run[i]) begin
                    if (rec) begin
                        m_run[i]   = 1'b1;
                        m_t[i]     = 0;
                        m_nb[i]    = 0;
                        m_ns[i]    = 0;
                        m_buf[i]   = '0;
                        exp_act[i] = (wm[i] == 0);
                    end
                end else if (!rec) begin
                    m_run[i]    = 1'b0;
                    exp_act[i]  = 1'b0;
                    exp_mclk[i] = 1'b0;
                end else begin
                    if ((m_t[i] + 1) % (2 * cd[i]) == 0) begin
                        m_buf[i][m_nb[i]] = mic_data;
                        m_nb[i]++;
                        if (m_nb[i] == dc[i]) begin
                            exp_din[i] = 8'($countones(m_buf[i]));
                            m_nb[i]    = 0;
                            m_buf[i]   = '0;
                            if (m_ns[i] < wm[i]) begin
                                m_ns[i]++;
                                if (m_ns[i] == wm[i]) exp_act[i] = 1'b1;
                            end else if (full) begin
                                exp_ovf[i] = 1'b1;
                            end else begin
                                exp_wr[i] = 1'b1;
                            end
                        end
                    end
                    m_t[i]++;
                    exp_mclk[i] = ((m_t[i] / cd[i]) % 2) == 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("mic_clk[%0d]", i),   32'(mclk[i]),  32'(exp_mclk[i]));
                check($sformatf("din[%0d]", i),       32'(din_v[i]), 32'(exp_din[i]));
                check($sformatf("wr[%0d]", i),        32'(wr_v[i]),  32'(exp_wr[i]));
                check($sformatf("overflow[%0d]", i),  32'(ovf[i]),   32'(exp_ovf[i]));
                check($sformatf("active[%0d]", i),    32'(act[i]),   32'(exp_act[i]));
                check($sformatf("mic_lrsel[%0d]", i), 32'(lrsel[i]), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts rising edges until wr of instance idx is seen; n = -1 on timeout.
    task automatic wait_wr(input int idx, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (wr_v[idx]) return;
        end
        n = -1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int k;
        int cnt;
        int first_k;
        int second_k;
        logic [7:0] first_din;
        logic [7:0] second_din;

        repeat (3) tick();
        reset = 1'b0;
        cmp_en = 1'b1;
        tick();
        @(negedge clock);
        check("rst_wr", 32'(wr_v), 32'd0);
        check("rst_mclk", 32'(mclk), 32'd0);
        check("rst_din2", 32'(din_v[2]), 32'd0);
        check("rst_ovf_act", 32'({ovf, act}), 32'd0);

        // All-ones stream on instance 2 (WARM=0).
        tick();
        mic_data = 1'b1;
        rec = 1'b1;
        wait_wr(2, 100, n);
        check("ones_first_wr_latency", 32'(n), 32'd33);
        check("ones_din", 32'(din_v[2]), 32'd8);
        wait_wr(2, 100, n);
        check("ones_period", 32'(n), 32'd32);
        check("ones_din2", 32'(din_v[2]), 32'd8);

        // Alternating stream, warm-up on instance 0 (WARM=2).
        rec = 1'b0;
        tick();
        tick();
        rec = 1'b1;
        mic_data = 1'b0;
        k = 0;
        cnt = 0;
        first_k = -1;
        second_k = -1;
        first_din = 8'hff;
        second_din = 8'hff;
        while (k < 140) begin
            tick();
            k++;
            if (k % 4 == 0) mic_data = ~mic_data;
            if (k <= 64 && wr_v[0]) cnt++;
            if (k == 64) check("alt_active_low", 32'(act[0]), 32'd0);
            if (k == 65) check("alt_active_high", 32'(act[0]), 32'd1);
            if (k > 64 && wr_v[0]) begin
                if (first_k < 0) begin
                    first_k = k;
                    first_din = din_v[0];
                end else if (second_k < 0) begin
                    second_k = k;
                    second_din = din_v[0];
                end
            end
        end
        check("alt_warm_no_wr", 32'(cnt), 32'd0);
        check("alt_first_wr_k", 32'(first_k), 32'd97);
        check("alt_first_din", 32'(first_din), 32'd4);
        check("alt_second_wr_k", 32'(second_k), 32'd129);
        check("alt_second_din", 32'(second_din), 32'd4);

        // Overflow on instance 2.
        mic_data = 1'b1;
        full = 1'b1;
        cnt = 0;
        repeat (96) begin
            tick();
            if (wr_v[2]) cnt++;
        end
        check("ovf_no_wr", 32'(cnt), 32'd0);
        check("ovf_set", 32'(ovf[2]), 32'd1);
        full = 1'b0;
        wait_wr(2, 40, n);
        check("ovf_resume_wr", 32'(n > 0), 32'd1);
        check("ovf_sticky", 32'(ovf[2]), 32'd1);
        check("ovf_resume_din", 32'(din_v[2]), 32'd8);

        // Abort at bitcnt=5 on instance 2, then restart with fresh zero bits.
        repeat (20) tick();
        rec = 1'b0;
        tick();
        check("abort_mclk", 32'(mclk[2]), 32'd0);
        check("abort_active", 32'(act[2]), 32'd0);
        cnt = 0;
        repeat (40) begin
            tick();
            if (wr_v[2]) cnt++;
        end
        check("abort_no_wr", 32'(cnt), 32'd0);
        mic_data = 1'b0;
        rec = 1'b1;
        wait_wr(2, 100, n);
        check("restart_wr_latency", 32'(n), 32'd33);
        check("restart_din", 32'(din_v[2]), 32'd0);
        wait_wr(0, 100, n);
        check("restart_warm_wr_delay", 32'(n), 32'd64);
        check("restart_warm_din", 32'(din_v[0]), 32'd0);

        // Max decimation on instance 1.
        mic_data = 1'b1;
        wait_wr(1, 1100, n);
        wait_wr(1, 1100, n);
        check("dec255_period", 32'(n), 32'd1020);
        check("dec255_ones", 32'(din_v[1]), 32'd255);
        mic_data = 1'b0;
        wait_wr(1, 1100, n);
        wait_wr(1, 1100, n);
        check("dec255_zero_period", 32'(n), 32'd1020);
        check("dec255_zeros", 32'(din_v[1]), 32'd0);

        // Asynchronous reset in the middle of a strobe.
        mic_data = 1'b1;
        wait_wr(2, 40, n);
        check("pre_reset_wr", 32'(wr_v[2]), 32'd1);
        #2;
        reset = 1'b1;
        rec = 1'b0;
        #1;
        check("async_rst_wr", 32'(wr_v), 32'd0);
        check("async_rst_mclk", 32'(mclk), 32'd0);
        check("async_rst_ovf", 32'(ovf), 32'd0);
        check("async_rst_act", 32'(act), 32'd0);
        check("async_rst_din2", 32'(din_v[2]), 32'd0);
        check("async_rst_din0", 32'(din_v[0]), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        cnt = 0;
        repeat (1000) begin
            tick();
            if (mclk != '0) cnt++;
        end
        check("idle_mclk_quiet", 32'(cnt), 32'd0);

        // Randomised traffic with occasional short and long recording gaps.
        rec = 1'b1;
        repeat (20000) begin
            tick();
            mic_data = 1'($urandom_range(0, 1));
            full = ($urandom_range(0, 7) == 0);
            if (rec && $urandom_range(0, 1499) == 0) rec = 1'b0;
            else if (!rec && $urandom_range(0, 3) != 0) rec = 1'b1;
        end
        rec = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
